// File: rtl/distribute_seq_pkg.sv
// Shared constants and pending-mask encoding for the 1-to-2 distribution node.
package distribute_seq_pkg;

  localparam int unsigned NUM_LANES  = 2;
  localparam int unsigned LANE_LO    = 0;
  localparam int unsigned LANE_HI    = 1;

  localparam logic [1:0] DEST_NONE  = 2'b00;
  localparam logic [1:0] DEST_LO    = 2'b01;
  localparam logic [1:0] DEST_HI    = 2'b10;
  localparam logic [1:0] DEST_BOTH  = 2'b11;

  // Per-lane pending mask {pend1, pend0} viewed as a node state.
  typedef enum logic [1:0] {
    PEND_IDLE = 2'b00,
    PEND_LO   = 2'b01,
    PEND_HI   = 2'b10,
    PEND_BOTH = 2'b11
  } pend_state_e;

endpackage

// File: rtl/distribute_lane_reg.sv
// One output lane: pending bit plus data register with load/drain/hold control.
module distribute_lane_reg #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic                  i_drain,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_pend,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  pend_q;
  logic                  pend_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Load wins over drain so a same-cycle drain and refill keeps the lane busy.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    if (rst) begin
      pend_d = 1'b0;
      data_d = {DATA_WIDTH{1'bx}};
    end else if (i_en) begin
      if (i_load) begin
        pend_d = 1'b1;
        data_d = i_data;
      end else if (i_drain) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    data_q <= data_d;
  end

  assign o_pend = pend_q;
  assign o_data = data_q;

endmodule

// File: rtl/distribute_seq.sv
// Sequential 1-to-2 distribution node: registers one word and presents it on lane 0, lane 1 or both.
module distribute_seq
  import distribute_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  input  logic [1:0]                i_dest,
  output logic                      o_ready,
  output logic [1:0]                o_valid,
  output logic [2*DATA_WIDTH-1:0]   o_data_bus,
  input  logic [1:0]                i_ready
);

  logic [NUM_LANES-1:0] pend;
  logic [NUM_LANES-1:0] load;
  logic [NUM_LANES-1:0] drain;
  logic [NUM_LANES-1:0] xfer;
  logic [DATA_WIDTH-1:0] lane_data [NUM_LANES];
  logic                  space_c;
  logic                  accept;
  pend_state_e           pend_state;

  assign pend_state = pend_state_e'(pend);

  // Room for a new word only when every pending lane drains this cycle, keeping multicast atomic.
  always_comb begin
    space_c = 1'b0;
    case (pend_state)
      PEND_IDLE: space_c = 1'b1;
      PEND_LO:   space_c = i_ready[LANE_LO];
      PEND_HI:   space_c = i_ready[LANE_HI];
      PEND_BOTH: space_c = i_ready[LANE_LO] & i_ready[LANE_HI];
      default:   space_c = 1'b0;
    endcase
  end

  assign o_ready = i_en & ~rst & space_c;
  assign o_valid = pend & {NUM_LANES{i_en & ~rst}};
  assign xfer    = o_valid & i_ready;
  assign accept  = i_valid & o_ready;

  // An untargeted lane on accept is already empty or transferring, so it simply clears.
  always_comb begin
    load  = {NUM_LANES{accept}} & i_dest;
    drain = xfer | ({NUM_LANES{accept}} & ~i_dest);
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    distribute_lane_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (i_en),
      .i_load  (load[k]),
      .i_drain (drain[k]),
      .i_data  (i_data_bus),
      .o_pend  (pend[k]),
      .o_data  (lane_data[k])
    );
  end

  assign o_data_bus = {lane_data[LANE_HI], lane_data[LANE_LO]};

endmodule

// File: tb/tb_distribute_seq.sv
// Directed bench for distribute_seq with a per-lane scoreboard checked by an independent monitor.
module tb_distribute_seq;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          i_en;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic [1:0]    i_dest;
  logic          o_ready;
  logic [1:0]    o_valid;
  logic [2*DW-1:0] o_data_bus;
  logic [1:0]    i_ready;

  int n_vec;
  int n_err;

  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  distribute_seq #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_dest     (i_dest),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each negedge record accepted words and check every lane transfer.
  always @(negedge clk) begin
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (o_valid[k] && i_ready[k]) begin
          got = (k == 0) ? o_data_bus[0+:DW] : o_data_bus[DW+:DW];
          n_vec++;
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            n_err++;
            $display("FAIL lane%0d_xfer: unexpected transfer data=%h, scoreboard empty", k, got);
          end else begin
            want = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got !== want) begin
              n_err++;
              $display("FAIL lane%0d_data: got %h expected %h", k, got, want);
            end
          end
        end
      end
      if (i_valid && o_ready) begin
        if (i_dest[0]) exp_q0.push_back(i_data_bus);
        if (i_dest[1]) exp_q1.push_back(i_data_bus);
      end
    end
  end

  // One cycle: drive inputs after posedge, check handshake outputs at negedge.
  task automatic cyc(input string name, input logic r, input logic en, input logic v,
                     input logic [DW-1:0] d, input logic [1:0] dest, input logic [1:0] rdy,
                     input logic exp_rdy, input logic [1:0] exp_vld);
    #1;
    rst = r; i_en = en; i_valid = v; i_data_bus = d; i_dest = dest; i_ready = rdy;
    @(negedge clk);
    n_vec++;
    if (o_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL %s o_ready: got %b expected %b", name, o_ready, exp_rdy);
    end
    n_vec++;
    if (o_valid !== exp_vld) begin
      n_err++;
      $display("FAIL %s o_valid: got %b expected %b", name, o_valid, exp_vld);
    end
    @(posedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_dest = 2'b00; i_ready = 2'b00;
    @(posedge clk);
    cyc("reset0", 1, 1, 0, 16'h0000, 2'b00, 2'b11, 0, 2'b00);
    cyc("reset1", 1, 1, 1, 16'h1111, 2'b11, 2'b11, 0, 2'b00);
    // 1: unicast lane 0
    cyc("t1_acc",  0, 1, 1, 16'h00A5, 2'b01, 2'b11, 1, 2'b00);
    cyc("t1_out",  0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b01);
    cyc("t1_idle", 0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b00);
    // 2: multicast back-to-back
    cyc("t2_acc0", 0, 1, 1, 16'h1234, 2'b11, 2'b11, 1, 2'b00);
    cyc("t2_acc1", 0, 1, 1, 16'h1235, 2'b11, 2'b11, 1, 2'b11);
    cyc("t2_out1", 0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b11);
    cyc("t2_idle", 0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b00);
    // 3: partial stall of a multicast
    cyc("t3_acc",   0, 1, 1, 16'h0F0F, 2'b11, 2'b11, 1, 2'b00);
    cyc("t3_stl0",  0, 1, 1, 16'hBEEF, 2'b01, 2'b01, 0, 2'b11);
    cyc("t3_stl1",  0, 1, 1, 16'hBEEF, 2'b01, 2'b01, 0, 2'b10);
    cyc("t3_stl2",  0, 1, 1, 16'hBEEF, 2'b01, 2'b01, 0, 2'b10);
    cyc("t3_rel",   0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b10);
    cyc("t3_idle",  0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b00);
    // 4: drop with empty mask, then a normal word
    cyc("t4_drop",  0, 1, 1, 16'hDEAD, 2'b00, 2'b11, 1, 2'b00);
    cyc("t4_next",  0, 1, 1, 16'h0055, 2'b01, 2'b11, 1, 2'b00);
    cyc("t4_out",   0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b01);
    // 5: enable freeze with lane 1 pending
    cyc("t5_acc",   0, 1, 1, 16'h0042, 2'b10, 2'b00, 1, 2'b00);
    cyc("t5_hold",  0, 1, 0, 16'h0000, 2'b00, 2'b00, 0, 2'b10);
    cyc("t5_frz0",  0, 0, 1, 16'h9999, 2'b11, 2'b11, 0, 2'b00);
    cyc("t5_frz1",  0, 0, 1, 16'h9999, 2'b11, 2'b11, 0, 2'b00);
    cyc("t5_back",  0, 1, 0, 16'h0000, 2'b00, 2'b00, 0, 2'b10);
    cyc("t5_xfer",  0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b10);
    cyc("t5_idle",  0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b00);
    // 6: reset while both lanes pending
    cyc("t6_acc",   0, 1, 1, 16'h0777, 2'b11, 2'b00, 1, 2'b00);
    cyc("t6_pend",  0, 1, 0, 16'h0000, 2'b00, 2'b00, 0, 2'b11);
    cyc("t6_rst",   1, 1, 0, 16'h0000, 2'b00, 2'b11, 0, 2'b00);
    cyc("t6_post0", 0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b00);
    cyc("t6_post1", 0, 1, 1, 16'h0088, 2'b10, 2'b11, 1, 2'b00);
    cyc("t6_out",   0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b10);
    cyc("t6_idle",  0, 1, 0, 16'h0000, 2'b00, 2'b11, 1, 2'b00);
    // All expected lane words must have been delivered.
    n_vec++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL drain_check: outstanding lane0=%0d lane1=%0d expected 0 0",
               exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
